nanov_store_capture: RTL

- Parametrised store-data capture buffer, successor to the single-register store capture used around nanoV_cpu.
- Sits on the CPU store-data output.
- Every word strobed by store_valid is queued in a DEPTH-entry FIFO, and the most recent word is mirrored in a holding register.
- A downstream consumer (bench monitor, UART or SPI drain) pops entries with a valid/ready handshake; FIFO-full behaviour is selectable: drop-newest or overwrite-oldest.

---
 rtl/nanov_store_capture.sv | 71 +++++++
 1 files changed

// File: rtl/nanov_store_capture.sv
// Store-data capture buffer: queues every CPU store word in a DEPTH-entry FIFO
// and mirrors the most recent word in a holding register.
module nanov_store_capture #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int OVERWRITE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       store_valid,
  input  logic [WIDTH-1:0]           store_data,
  output logic [WIDTH-1:0]           last_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam bit OVW = (OVERWRITE != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             full_event;
  logic             do_write;
  logic             adv_rd;

  // A full-FIFO event is a push that finds no room because nothing pops this cycle;
  // in overwrite mode it still writes and evicts the oldest word by advancing rd_ptr.
  always_comb begin
    full       = (count == FULL_COUNT);
    pop        = out_valid && out_ready;
    full_event = store_valid && full && !pop;
    do_write   = store_valid && (!full_event || OVW);
    adv_rd     = pop || (full_event && OVW);
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= store_data;
  end

  // Set beats clear so a full event coinciding with clear_overflow is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      last_data <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (adv_rd)   rd_ptr <= rd_ptr + AW'(1);
      if (do_write && !adv_rd)      count <= count + CW'(1);
      else if (adv_rd && !do_write) count <= count - CW'(1);
      if (full_event)          overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
      if (store_valid) last_data <= store_data;
    end
  end

endmodule
